fifo_wr_arb: RTL
================

Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter with burst locking. It shares the single write port of the 16-deep, 8-bit `fifo` between N requesters.
- Keeps a credit counter that mirrors FIFO occupancy, so it never issues `we` into a full FIFO, even though its write outputs are registered.
- Sits between producer blocks and the `fifo` we/data_in pins. The consumer drives `fifo` `re` directly; this block only observes it.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 8, data width; must equal the fifo data width.
- DEPTH, 16, fifo depth; the credit limit.
- BURST_MAX, 4, maximum consecutive beats one owner may hold the port (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  requester i has a beat on req_data slice i.
- req_data  in  N*DW  packed data; slice i is bits [i*DW +: DW].
- gnt  out  N  one-hot, combinational; gnt[i]=1 means slice i is accepted at this edge.
- fifo_we  out  1  registered write enable to `fifo` we.
- fifo_din  out  DW  registered data to `fifo` data_in.
- fifo_re  in  1  tap of the consumer's read enable to `fifo`.
- fifo_full  in  1  fifo full flag.
- fifo_empty  in  1  fifo empty flag.
- credit  out  5  current reserved occupancy, 0..DEPTH.
- ovf_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at an edge): gnt=0, fifo_we=0, fifo_din=0, credit=0, ovf_err=0, state=IDLE, ptr=0, beat=0, owner=0. A reset mid-burst abandons the burst; a beat already registered is dropped. Software must also reset `fifo` in the same cycle.
- can_acc = (credit < DEPTH) && !fifo_full.
- rd = fifo_re && !fifo_empty.
- credit next value = credit + (|gnt) - rd. A simultaneous grant and read leaves credit unchanged. credit saturates at 0 and DEPTH; hitting either bound with a further decrement/increment is a design bug, flagged by an assertion.
- Write path: when gnt[i]=1, fifo_din <= slice i and fifo_we <= 1 at the same edge; otherwise fifo_we <= 0. Latency from req to fifo_we is 1 cycle, so at most one beat per cycle.
- FSM states:
  - IDLE: if |req && can_acc, winner = first i with req[i]=1, searching upward from ptr with wrap at N. Assert gnt[winner], set owner=winner, beat=1, go to OWN. If |req && !can_acc, no grant; stay in IDLE. The winner is re-evaluated each cycle in IDLE.
  - OWN: if !req[owner], go to IDLE with ptr=owner+1 mod N. Else if !can_acc, go to STALL (no grant, beat held). Else if beat==BURST_MAX, no grant this cycle, go to IDLE with ptr=owner+1 mod N. Else assert gnt[owner], beat=beat+1.
  - STALL: if !req[owner], go to IDLE with ptr=owner+1. Else if can_acc, assert gnt[owner], beat+1, go to OWN. If beat reaches BURST_MAX via this grant, the next OWN cycle releases.
- Requesters must hold req and data stable until gnt; dropping req without gnt is legal and ends ownership.
- gnt is never asserted for a requester whose req=0, and never when can_acc=0.
- ovf_err sets when fifo_we=1 && fifo_full=1 at an edge. It clears only on rst.
- Wrap-around: ptr advances modulo N. With N=4 and owner=3, ptr becomes 0.

Decomposition:
- Package fifo_arb_pkg holds the state encoding (IDLE=2'd0, OWN=2'd1, STALL=2'd2), the CREDIT_W=5 constant, and a function rr_pick(req, ptr) returning the winner index.
- One sub-module is natural: rr_prio_enc, a combinational rotate/priority-encode/unrotate that is parameterised by N. Credit counter and FSM stay in the top module.

Test Plan:
- Single requester: after rst, req=4'b0001 held with data 0..15 → gnt[0] pattern is 4 grants then 1 idle cycle, repeating. 16 fifo_we pulses carry 0..15 in order; credit reaches 16; fifo_full=1; then no further grants and ovf_err=0.
- Round-robin: req=4'b1111 constant, no reads → owners are 0,1,2,3, each with 4 beats. Credit reaches 16 after 16 grants and gnt stays 0 afterwards.
- Burst cut by req drop: req[2]=1 for 2 beats then 0, while req[0]=1 → 2 beats from 2, one IDLE cycle, then owner 0 (ptr=3 wraps to 0).
- Stall and resume: credit=16 with req[1] held → state STALL. Pulse fifo_re for 1 cycle with fifo_empty=0 → credit 15, then one grant to 1, then credit 16 again.
- Simultaneous grant and read: credit=8, gnt and rd in the same cycle → credit stays 8. A read with fifo_empty=1 does not decrement.
- Reset mid-burst: rst during OWN at beat 2 → all outputs 0 next cycle, credit=0, ptr=0. The next grant goes to the lowest active requester.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned CREDIT_W = 5;
  localparam int unsigned BEAT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Reference round-robin pick: first set bit at or above ptr, wrapping at n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input int unsigned n,
                                         input logic [2:0] ptr);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_prio_enc.sv
// Round-robin priority encoder: rotate by ptr, pick lowest set bit, rotate back.
module rr_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_o,
  output logic [PW-1:0] idx_o
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;
  int unsigned   j;

  // Rotate so ptr sits at bit 0, find the first requester, map back to absolute index.
  always_comb begin
    rot = '0;
    j   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = i + 32'(ptr_i);
      if (j >= N) j = j - N;
      rot[i] = req_i[j[PW-1:0]];
    end
    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = PW'(i - 1);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx_o = sum[PW-1:0];
    any_o = |req_i;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter with burst locking and FIFO credit tracking.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DW-1:0]     req_data,
  output logic [N-1:0]        gnt,
  output logic                fifo_we,
  output logic [DW-1:0]       fifo_din,
  input  logic                fifo_re,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  output logic [CREDIT_W-1:0] credit,
  output logic                ovf_err
);

  localparam int unsigned PW = $clog2(N);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                we_q, we_d;
  logic [DW-1:0]       din_q, din_d;
  logic                ovf_q, ovf_d;

  logic                can_acc, rd;
  logic                win_any;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       ptr_after_owner;
  logic [BEAT_W-1:0]   beat_inc;
  logic [7:0]          req8;
  logic [2:0]          ptr8;

  rr_prio_enc #(.N(N), .PW(PW)) u_enc (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (win_any),
    .idx_o (win_idx)
  );

  assign can_acc         = (credit_q < CREDIT_W'(DEPTH)) && !fifo_full;
  assign rd              = fifo_re && !fifo_empty;
  assign ptr_after_owner = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
  // Beat saturates at BURST_MAX so a grant out of STALL at the limit cannot run past the release check.
  assign beat_inc        = (beat_q < BEAT_W'(BURST_MAX)) ? beat_q + 1'b1 : beat_q;

  // Arbitration FSM next state and combinational grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    gnt     = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (win_any && can_acc) begin
            gnt[win_idx] = 1'b1;
            owner_d      = win_idx;
            beat_d       = BEAT_W'(1);
            state_d      = OWN;
          end
        end
        OWN: begin
          if (!req[owner_q]) begin
            state_d = IDLE;
            ptr_d   = ptr_after_owner;
          end else if (!can_acc) begin
            state_d = STALL;
          end else if (beat_q >= BEAT_W'(BURST_MAX)) begin
            state_d = IDLE;
            ptr_d   = ptr_after_owner;
          end else begin
            gnt[owner_q] = 1'b1;
            beat_d       = beat_inc;
          end
        end
        STALL: begin
          if (!req[owner_q]) begin
            state_d = IDLE;
            ptr_d   = ptr_after_owner;
          end else if (can_acc) begin
            gnt[owner_q] = 1'b1;
            beat_d       = beat_inc;
            state_d      = OWN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-path data select, credit update and sticky overflow detect.
  always_comb begin
    din_d = din_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) din_d = req_data[i*DW +: DW];
    end
    we_d     = |gnt;
    credit_d = credit_q;
    case ({|gnt, rd})
      2'b10:   if (credit_q != CREDIT_W'(DEPTH)) credit_d = credit_q + 1'b1;
      2'b01:   if (credit_q != '0) credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
    ovf_d = ovf_q | (we_q & fifo_full);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
      credit_q <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      credit_q <= credit_d;
      we_q     <= we_d;
      din_q    <= din_d;
      ovf_q    <= ovf_d;
    end
  end

  // Widened copies for the reference pick function.
  always_comb begin
    req8          = '0;
    req8[N-1:0]   = req;
    ptr8          = '0;
    ptr8[PW-1:0]  = ptr_q;
  end

  // Credit must never be pushed past its bounds; IDLE winner must match the reference pick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(credit_q == CREDIT_W'(DEPTH) && (|gnt) && !rd))
        else $error("credit overflow");
      assert (!(credit_q == '0 && rd && !(|gnt)))
        else $error("credit underflow");
      if (state_q == IDLE && (|gnt))
        assert (3'(win_idx) == rr_pick(req8, N, ptr8))
          else $error("round-robin pick disagrees with reference");
    end
  end

  assign fifo_we  = we_q;
  assign fifo_din = din_q;
  assign credit   = credit_q;
  assign ovf_err  = ovf_q;

endmodule
